// File: rtl/counter_read_master.sv
// Initiator for the two-beat event-counter read: an atomic low-half request followed
// by a high-half request, assembled into one 64-bit value with protocol/monotonic checks.
module counter_read_master #(
  parameter  int PERIOD = 16,
  localparam int PW     = $clog2(PERIOD)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        auto_en_i,
  input  logic        clr_err_i,
  output logic        ready_o,
  output logic        req_o,
  output logic        atomic_o,
  input  logic        ack_i,
  input  logic [31:0] count_i,
  output logic [63:0] data_o,
  output logic        valid_o,
  output logic        ack_err_o,
  output logic        mono_err_o
);

  localparam logic [1:0]    IDLE     = 2'd0;
  localparam logic [1:0]    LO       = 2'd1;
  localparam logic [1:0]    HI       = 2'd2;
  localparam logic [1:0]    CAP      = 2'd3;
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [PW-1:0] per_cnt_r;
  logic          pending_r;
  logic          first_r;
  logic          abort_r;
  logic [31:0]   lo_r;
  logic [63:0]   prev_r;
  logic [63:0]   data_r;
  logic          valid_r;
  logic          ack_err_r;
  logic          mono_err_r;

  logic          tick_s;
  logic          go_s;
  logic          accept_s;
  logic          rd_ok_s;
  logic          rd_bad_s;
  logic          stray_s;
  logic          mono_set_s;
  logic [63:0]   rd_val_s;

  // Next-state selection and per-cycle event decode
  always_comb begin
    tick_s      = auto_en_i && (per_cnt_r == PER_LAST);
    go_s        = start_i || pending_r;
    accept_s    = 1'b0;
    rd_ok_s     = 1'b0;
    rd_bad_s    = 1'b0;
    stray_s     = 1'b0;
    rd_val_s    = {count_i, lo_r};
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        stray_s  = ack_i;
        accept_s = go_s;
        if (go_s) begin
          state_nxt_s = LO;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LO: begin
        stray_s     = ack_i;
        state_nxt_s = HI;
      end
      HI: begin
        state_nxt_s = CAP;
      end
      CAP: begin
        rd_ok_s  = ack_i && !abort_r;
        rd_bad_s = !(ack_i && !abort_r);
        accept_s = go_s;
        if (go_s) begin
          state_nxt_s = LO;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    mono_set_s = rd_ok_s && first_r && (rd_val_s < prev_r);
  end

  // Protocol state, auto-read scheduling and low-beat capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      per_cnt_r <= {PW{1'b0}};
      pending_r <= 1'b0;
      abort_r   <= 1'b0;
      lo_r      <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      if (!auto_en_i || tick_s) begin
        per_cnt_r <= {PW{1'b0}};
      end else begin
        per_cnt_r <= per_cnt_r + PW'(1'b1);
      end
      // An accepted start consumes the request even if a tick lands on the same edge
      if (accept_s) begin
        pending_r <= 1'b0;
      end else if (tick_s) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      if (state_r == HI) begin
        abort_r <= !ack_i;
      end else if (state_r == CAP) begin
        abort_r <= 1'b0;
      end else begin
        abort_r <= abort_r;
      end
      if ((state_r == HI) && ack_i) begin
        lo_r <= count_i;
      end else begin
        lo_r <= lo_r;
      end
    end
  end

  // Result assembly, status pulses and sticky monotonic error
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_r     <= 64'h0;
      prev_r     <= 64'h0;
      first_r    <= 1'b0;
      valid_r    <= 1'b0;
      ack_err_r  <= 1'b0;
      mono_err_r <= 1'b0;
    end else begin
      valid_r   <= rd_ok_s;
      ack_err_r <= rd_bad_s || stray_s;
      if (rd_ok_s) begin
        data_r  <= rd_val_s;
        prev_r  <= rd_val_s;
        first_r <= 1'b1;
      end else begin
        data_r  <= data_r;
        prev_r  <= prev_r;
        first_r <= first_r;
      end
      if (mono_set_s) begin
        mono_err_r <= 1'b1;
      end else if (clr_err_i) begin
        mono_err_r <= 1'b0;
      end else begin
        mono_err_r <= mono_err_r;
      end
    end
  end

  assign ready_o    = (state_r == IDLE) || (state_r == CAP);
  assign req_o      = (state_r == LO) || (state_r == HI);
  assign atomic_o   = (state_r == LO);
  assign data_o     = data_r;
  assign valid_o    = valid_r;
  assign ack_err_o  = ack_err_r;
  assign mono_err_o = mono_err_r;

endmodule

// File: tb/tb_counter_read_master.sv
// Bench for counter_read_master: a snapshotting counter responder plus a
// transaction-level model of read results, error pulses and the monotonic flag.
module tb_counter_read_master;
  localparam int PERIOD = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic        auto_en_i = 1'b0;
  logic        clr_err_i = 1'b0;
  logic        ready_o, req_o, atomic_o, valid_o, ack_err_o, mono_err_o;
  logic        ack_i;
  logic [31:0] count_i;
  logic [63:0] data_o;

  logic [63:0] ctr, snap;
  logic [63:0] load_val = 64'h0;
  logic        load_req = 1'b0;
  logic        trig = 1'b0;
  logic        drop_lo = 1'b0;
  logic        stray_ack = 1'b0;

  int          n_checks = 0;
  int          n_pass = 0;

  logic [63:0] m_prev, m_data;
  logic        m_first, m_mono;

  counter_read_master #(.PERIOD(PERIOD)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .auto_en_i(auto_en_i),
    .clr_err_i(clr_err_i), .ready_o(ready_o), .req_o(req_o), .atomic_o(atomic_o),
    .ack_i(ack_i), .count_i(count_i), .data_o(data_o), .valid_o(valid_o),
    .ack_err_o(ack_err_o), .mono_err_o(mono_err_o)
  );

  always #5 clk = ~clk;

  // Counter responder: snapshot on the atomic request, low beat then high beat
  always @(posedge clk) begin
    if (load_req) ctr <= load_val;
    else if (trig) ctr <= ctr + 64'd1;
    if (!reset) begin
      ack_i <= 1'b0; count_i <= 32'h0; snap <= 64'h0;
    end else if (req_o && atomic_o) begin
      snap <= ctr; ack_i <= ~drop_lo; count_i <= ctr[31:0];
    end else if (req_o) begin
      ack_i <= 1'b1; count_i <= snap[63:32];
    end else begin
      ack_i <= stray_ack; count_i <= 32'h0;
    end
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_prev = 64'h0; m_data = 64'h0; m_first = 1'b0; m_mono = 1'b0;
  endtask

  task automatic model_read(input logic [63:0] val, input bit clr);
    if (m_first && (val < m_prev)) m_mono = 1'b1;
    else if (clr) m_mono = 1'b0;
    m_prev = val; m_first = 1'b1; m_data = val;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    chk_eq("reset_flags", {ready_o, req_o, atomic_o, valid_o, ack_err_o, mono_err_o}, 6'b100000);
    chk_eq("reset_data", data_o, 64'h0);
    reset = 1'b1;
    model_reset();
  endtask

  // One complete read starting from idle; phase outputs checked on the way
  task automatic run_read(input logic [63:0] v, input bit tr, input bit drop, input bit stray,
                          input bit clr, output logic gv, output logic [63:0] gd, output int errs);
    load_val = v; load_req = 1'b1; trig = tr;
    @(negedge clk);
    load_req = 1'b0; start_i = 1'b1; drop_lo = drop; stray_ack = stray;
    @(negedge clk);
    start_i = 1'b0; stray_ack = 1'b0;
    chk_eq("lo_phase", {ready_o, req_o, atomic_o, valid_o}, 4'b0110);
    errs = int'(ack_err_o);
    @(negedge clk);
    drop_lo = 1'b0;
    chk_eq("hi_phase", {ready_o, req_o, atomic_o, valid_o}, 4'b0100);
    errs += int'(ack_err_o);
    @(negedge clk);
    chk_eq("cap_phase", {ready_o, req_o, atomic_o, valid_o}, 4'b1000);
    errs += int'(ack_err_o);
    clr_err_i = clr;
    @(negedge clk);
    clr_err_i = 1'b0;
    gv = valid_o; gd = data_o;
    errs += int'(ack_err_o);
  endtask

  task automatic expect_read(input logic [63:0] v, input bit tr, input bit drop,
                             input bit stray, input bit clr);
    logic gv;
    logic [63:0] gd;
    int errs;
    run_read(v, tr, drop, stray, clr, gv, gd, errs);
    if (!drop) model_read(tr ? v + 64'd1 : v, clr);
    else if (clr) m_mono = 1'b0;
    chk_eq("rd_valid", gv, !drop);
    chk_eq("rd_data", gd, m_data);
    chk_eq("rd_ack_err_cnt", errs, int'(drop) + int'(stray));
    chk_eq("rd_mono", mono_err_o, m_mono);
  endtask

  initial begin
    logic [63:0] base;
    bit exp_v;
    model_reset();
    do_reset();

    // Unexpected ack while idle
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    chk_eq("stray_idle_err", ack_err_o, 1'b1);
    @(negedge clk);
    chk_eq("stray_idle_err_clr", ack_err_o, 1'b0);

    // Snapshot across a low-half carry: expect 0x1_FFFF_FFFF, never a torn value
    expect_read(64'h0000_0001_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_eq("valid_one_shot", valid_o, 1'b0);
    chk_eq("data_hold", data_o, 64'h0000_0001_FFFF_FFFF);

    // start_i held for 9 cycles: three back-to-back reads
    base = {$urandom, $urandom} >> 2;
    load_val = base; load_req = 1'b1; trig = 1'b1;
    @(negedge clk);
    load_req = 1'b0; start_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 9) start_i = 1'b0;
      @(negedge clk);
      exp_v = (k == 3) || (k == 6) || (k == 9);
      chk_eq("b2b_valid", valid_o, exp_v);
      if (exp_v) begin
        model_read(base + 64'(k) - 64'd2, 1'b0);
        chk_eq("b2b_data", data_o, m_data);
      end
    end
    chk_eq("b2b_mono", mono_err_o, m_mono);

    // Missing ack in HI, then a clean read
    expect_read({$urandom, $urandom}, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_eq("abort_idle", {ready_o, req_o}, 2'b10);
    expect_read(m_prev + 64'd100, 1'b1, 1'b0, 1'b0, 1'b0);

    // Monotonic flag: set, sticky, clear, set-wins, equal legal
    do_reset();
    expect_read(64'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_read(64'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk_eq("mono_sticky", mono_err_o, 1'b1);
    expect_read(64'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0; m_mono = 1'b0;
    chk_eq("mono_clr", mono_err_o, m_mono);
    expect_read(64'h2, 1'b0, 1'b0, 1'b0, 1'b1);
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0; m_mono = 1'b0;
    chk_eq("mono_clr2", mono_err_o, m_mono);
    expect_read(64'h2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Auto reads every PERIOD cycles; a start on the tick at edge 47 gives one read
    do_reset();
    base = {$urandom, $urandom} >> 2;
    load_val = base; load_req = 1'b1; trig = 1'b1;
    @(negedge clk);
    load_req = 1'b0; auto_en_i = 1'b1;
    for (int k = 0; k <= 70; k++) begin
      start_i = (k == 47);
      @(negedge clk);
      exp_v = (k == PERIOD + 3) || (k == 2 * PERIOD + 3) || (k == 50) || (k == 4 * PERIOD + 3);
      chk_eq("auto_valid", valid_o, exp_v);
      if (exp_v) begin
        model_read(base + 64'(k) - 64'd2, 1'b0);
        chk_eq("auto_data", data_o, m_data);
      end
    end
    start_i = 1'b0; auto_en_i = 1'b0;
    @(negedge clk);

    // Randomized reads against the transaction model
    for (int i = 0; i < 24; i++) begin
      logic [63:0] v;
      case ($urandom_range(0, 2))
        0: v = {$urandom, $urandom};
        1: v = m_prev + 64'($urandom_range(0, 5));
        default: v = m_prev - 64'($urandom_range(0, 5));
      endcase
      expect_read(v, 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        @(negedge clk);
        chk_eq("gap_quiet", {valid_o, ack_err_o}, 2'b00);
      end
    end

    // Reset while in HI abandons the read
    load_val = {$urandom, $urandom}; load_req = 1'b1; trig = 1'b1;
    @(negedge clk);
    load_req = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk_eq("pre_reset_hi", {req_o, atomic_o}, 2'b10);
    do_reset();
    repeat (3) begin
      @(negedge clk);
      chk_eq("post_reset_quiet", {valid_o, ack_err_o, req_o}, 3'b000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
